// File: rtl/id_ex_operand_stage.sv
// ID/EX stage: registers decoded fields, forwards from EX/MEM and MEM/WB,
// drives the ALU operands and detects load-use hazards.

module id_ex_fwd #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);
  always_comb begin
    fwd_data = rs_data;
    if (rs_addr != '0) begin
      if (mem_reg_write && mem_rd_addr == rs_addr)     fwd_data = mem_result;
      else if (wb_reg_write && wb_rd_addr == rs_addr)  fwd_data = wb_result;
    end
  end
endmodule

module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ID_VALID,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [XLEN-1:0] ID_RS1_DATA,
  input  logic [XLEN-1:0] ID_RS2_DATA,
  input  logic [XLEN-1:0] ID_IMM,
  input  logic [RA_W-1:0] ID_RS1_ADDR,
  input  logic [RA_W-1:0] ID_RS2_ADDR,
  input  logic [RA_W-1:0] ID_RD_ADDR,
  input  logic            ID_RS1_USED,
  input  logic            ID_RS2_USED,
  input  logic            ID_OP1_SEL,
  input  logic            ID_OP2_SEL,
  input  logic [5:0]      ID_ALU_SELECT,
  input  logic            ID_REG_WRITE,
  input  logic            ID_MEM_READ,
  input  logic            ID_MEM_WRITE,
  input  logic [RA_W-1:0] MEM_RD_ADDR,
  input  logic            MEM_REG_WRITE,
  input  logic [XLEN-1:0] MEM_RESULT,
  input  logic [RA_W-1:0] WB_RD_ADDR,
  input  logic            WB_REG_WRITE,
  input  logic [XLEN-1:0] WB_RESULT,
  input  logic            FLUSH,
  input  logic            MEM_STALL,
  output logic            ID_STALL,
  output logic [XLEN-1:0] ALU_DATA1,
  output logic [XLEN-1:0] ALU_DATA2,
  output logic [5:0]      ALU_SELECT,
  output logic            EX_VALID,
  output logic            EX_REG_WRITE,
  output logic            EX_MEM_READ,
  output logic            EX_MEM_WRITE,
  output logic [RA_W-1:0] EX_RD_ADDR,
  output logic [XLEN-1:0] EX_PC,
  output logic [XLEN-1:0] EX_STORE_DATA
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic            rs1_used;
    logic            rs2_used;
    logic [RA_W-1:0] rd;
    logic            op1_sel;
    logic            op2_sel;
    logic [5:0]      alu_sel;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } stage_t;

  stage_t st, id_st;
  logic   hz;

  // index 0 = rs1, index 1 = rs2
  logic [1:0][RA_W-1:0] src_addr;
  logic [1:0][XLEN-1:0] src_data;
  logic [1:0][XLEN-1:0] fwd;

  assign src_addr = {st.rs2_addr, st.rs1_addr};
  assign src_data = {st.rs2_data, st.rs1_data};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    id_ex_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
      .rs_addr       (src_addr[g]),
      .rs_data       (src_data[g]),
      .mem_rd_addr   (MEM_RD_ADDR),
      .mem_reg_write (MEM_REG_WRITE),
      .mem_result    (MEM_RESULT),
      .wb_rd_addr    (WB_RD_ADDR),
      .wb_reg_write  (WB_REG_WRITE),
      .wb_result     (WB_RESULT),
      .fwd_data      (fwd[g])
    );
  end

  assign hz = ID_VALID && st.valid && st.mem_read && st.rd != '0 &&
              ((ID_RS1_USED && ID_RS1_ADDR == st.rd) ||
               (ID_RS2_USED && ID_RS2_ADDR == st.rd));
  assign ID_STALL = hz || MEM_STALL;

  always_comb begin
    id_st           = '0;
    id_st.valid     = ID_VALID;
    id_st.pc        = ID_PC;
    id_st.rs1_data  = ID_RS1_DATA;
    id_st.rs2_data  = ID_RS2_DATA;
    id_st.imm       = ID_IMM;
    id_st.rs1_addr  = ID_RS1_ADDR;
    id_st.rs2_addr  = ID_RS2_ADDR;
    id_st.rs1_used  = ID_RS1_USED;
    id_st.rs2_used  = ID_RS2_USED;
    id_st.rd        = ID_RD_ADDR;
    id_st.op1_sel   = ID_OP1_SEL;
    id_st.op2_sel   = ID_OP2_SEL;
    id_st.alu_sel   = ID_ALU_SELECT;
    id_st.reg_write = ID_VALID && ID_REG_WRITE;
    id_st.mem_read  = ID_VALID && ID_MEM_READ;
    id_st.mem_write = ID_VALID && ID_MEM_WRITE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st <= '0;
    end else if (MEM_STALL) begin
      // refresh operands so a WB-forwarded value survives WB retiring
      st.rs1_data <= fwd[0];
      st.rs2_data <= fwd[1];
    end else if (FLUSH || hz) begin
      st <= '0;
    end else begin
      st <= id_st;
    end
  end

  assign ALU_DATA1     = st.op1_sel ? st.pc  : fwd[0];
  assign ALU_DATA2     = st.op2_sel ? st.imm : fwd[1];
  assign EX_STORE_DATA = fwd[1];
  assign ALU_SELECT    = st.alu_sel;
  assign EX_VALID      = st.valid;
  assign EX_REG_WRITE  = st.reg_write;
  assign EX_MEM_READ   = st.mem_read;
  assign EX_MEM_WRITE  = st.mem_write;
  assign EX_RD_ADDR    = st.rd;
  assign EX_PC         = st.pc;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table plus hazard/stall/reset sequences.

module tb_id_ex_operand_stage;
  logic        CLK, RESET;
  logic        ID_VALID;
  logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR;
  logic        ID_RS1_USED, ID_RS2_USED, ID_OP1_SEL, ID_OP2_SEL;
  logic [5:0]  ID_ALU_SELECT;
  logic        ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE;
  logic [4:0]  MEM_RD_ADDR, WB_RD_ADDR;
  logic        MEM_REG_WRITE, WB_REG_WRITE;
  logic [31:0] MEM_RESULT, WB_RESULT;
  logic        FLUSH, MEM_STALL;
  logic        ID_STALL;
  logic [31:0] ALU_DATA1, ALU_DATA2, EX_PC, EX_STORE_DATA;
  logic [5:0]  ALU_SELECT;
  logic        EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE;
  logic [4:0]  EX_RD_ADDR;

  int total = 0;
  int bad   = 0;

  id_ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
    .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .ID_OP1_SEL(ID_OP1_SEL), .ID_OP2_SEL(ID_OP2_SEL), .ID_ALU_SELECT(ID_ALU_SELECT),
    .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
    .MEM_RD_ADDR(MEM_RD_ADDR), .MEM_REG_WRITE(MEM_REG_WRITE), .MEM_RESULT(MEM_RESULT),
    .WB_RD_ADDR(WB_RD_ADDR), .WB_REG_WRITE(WB_REG_WRITE), .WB_RESULT(WB_RESULT),
    .FLUSH(FLUSH), .MEM_STALL(MEM_STALL), .ID_STALL(ID_STALL),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
    .EX_VALID(EX_VALID), .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ),
    .EX_MEM_WRITE(EX_MEM_WRITE), .EX_RD_ADDR(EX_RD_ADDR), .EX_PC(EX_PC),
    .EX_STORE_DATA(EX_STORE_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic        op1, op2;
    logic [5:0]  sel;
    logic        rw;
    logic [4:0]  mrd;
    logic        mrw;
    logic [31:0] mres;
    logic [4:0]  wrd;
    logic        wrw;
    logic [31:0] wres;
    logic        flush;
    logic        e_valid;
    logic [31:0] e_d1, e_d2, e_sd;
    logic [5:0]  e_sel;
    logic        e_rw;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    ID_VALID = 0; ID_PC = 0; ID_RS1_DATA = 0; ID_RS2_DATA = 0; ID_IMM = 0;
    ID_RS1_ADDR = 0; ID_RS2_ADDR = 0; ID_RD_ADDR = 0;
    ID_RS1_USED = 0; ID_RS2_USED = 0; ID_OP1_SEL = 0; ID_OP2_SEL = 0;
    ID_ALU_SELECT = 0; ID_REG_WRITE = 0; ID_MEM_READ = 0; ID_MEM_WRITE = 0;
    MEM_RD_ADDR = 0; MEM_REG_WRITE = 0; MEM_RESULT = 0;
    WB_RD_ADDR = 0; WB_REG_WRITE = 0; WB_RESULT = 0;
    FLUSH = 0; MEM_STALL = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input vec_t v);
    ID_VALID = v.valid; ID_PC = v.pc; ID_RS1_DATA = v.rs1d; ID_RS2_DATA = v.rs2d;
    ID_IMM = v.imm; ID_RS1_ADDR = v.rs1a; ID_RS2_ADDR = v.rs2a; ID_RD_ADDR = v.rd;
    ID_RS1_USED = 1; ID_RS2_USED = 1; ID_OP1_SEL = v.op1; ID_OP2_SEL = v.op2;
    ID_ALU_SELECT = v.sel; ID_REG_WRITE = v.rw; ID_MEM_READ = 0; ID_MEM_WRITE = 0;
    MEM_RD_ADDR = v.mrd; MEM_REG_WRITE = v.mrw; MEM_RESULT = v.mres;
    WB_RD_ADDR = v.wrd; WB_REG_WRITE = v.wrw; WB_RESULT = v.wres;
    FLUSH = v.flush; MEM_STALL = 0;
  endtask

  initial begin
    vec_t d, v;
    d = '{valid:1, pc:32'h100, rs1d:0, rs2d:0, imm:0, rs1a:0, rs2a:0, rd:0,
          op1:0, op2:0, sel:0, rw:1, mrd:0, mrw:0, mres:0, wrd:0, wrw:0, wres:0,
          flush:0, e_valid:1, e_d1:0, e_d2:0, e_sd:0, e_sel:0, e_rw:1, e_rd:0};
    // pass-through add x3,x1,x2
    v = d; v.rs1a = 1; v.rs1d = 5; v.rs2a = 2; v.rs2d = 7; v.rd = 3;
    v.e_d1 = 5; v.e_d2 = 7; v.e_sd = 7; v.e_rd = 3; tbl.push_back(v);
    // MEM beats WB on x3
    v = d; v.rs1a = 3; v.rs1d = 32'h11; v.rs2a = 4; v.rs2d = 32'h22; v.op2 = 1;
    v.imm = 32'h40; v.sel = 6'h05; v.rd = 8; v.mrd = 3; v.mrw = 1; v.mres = 32'hAA;
    v.wrd = 3; v.wrw = 1; v.wres = 32'hBB;
    v.e_d1 = 32'hAA; v.e_d2 = 32'h40; v.e_sd = 32'h22; v.e_sel = 6'h05; v.e_rd = 8;
    tbl.push_back(v);
    // MEM write disabled: WB wins
    v.mrw = 0; v.e_d1 = 32'hBB; tbl.push_back(v);
    // x0 never forwarded
    v = d; v.rs1a = 0; v.rs1d = 32'h11; v.mrd = 0; v.mrw = 1; v.mres = 32'hAA;
    v.wrd = 0; v.wrw = 1; v.wres = 32'hBB; v.e_d1 = 32'h11; tbl.push_back(v);
    // rs1 from MEM, rs2 from WB
    v = d; v.rs1a = 1; v.rs1d = 9; v.rs2a = 7; v.rs2d = 32'h33; v.rd = 12;
    v.mrd = 1; v.mrw = 1; v.mres = 32'hC0DE; v.wrd = 7; v.wrw = 1; v.wres = 32'h77;
    v.e_d1 = 32'hC0DE; v.e_d2 = 32'h77; v.e_sd = 32'h77; v.e_rd = 12; tbl.push_back(v);
    // PC and IMM operands; store data still forwarded
    v = d; v.pc = 32'h2000; v.op1 = 1; v.op2 = 1; v.imm = 32'hFFFF_FFFC;
    v.rs2a = 5; v.rs2d = 32'h55; v.wrd = 5; v.wrw = 1; v.wres = 32'h99; v.sel = 6'h21;
    v.e_d1 = 32'h2000; v.e_d2 = 32'hFFFF_FFFC; v.e_sd = 32'h99; v.e_sel = 6'h21;
    tbl.push_back(v);
    // invalid decode slot: controls cleared, data fields still loaded
    v = d; v.valid = 0; v.rs1a = 8; v.rs1d = 32'h44; v.rs2a = 9; v.rs2d = 32'h66; v.rd = 9;
    v.e_valid = 0; v.e_rw = 0; v.e_d1 = 32'h44; v.e_d2 = 32'h66; v.e_sd = 32'h66; v.e_rd = 9;
    tbl.push_back(v);
    // flush: bubble
    v = d; v.rs1a = 1; v.rs1d = 5; v.rd = 4; v.sel = 6'h0C; v.flush = 1;
    v.e_valid = 0; v.e_rw = 0; tbl.push_back(v);

    clr_inputs();
    RESET = 1;
    #2;
    chk("reset_valid", 32'(EX_VALID), 0);
    chk("reset_data1", ALU_DATA1, 0);
    chk("reset_data2", ALU_DATA2, 0);
    chk("reset_store", EX_STORE_DATA, 0);
    chk("reset_sel", 32'(ALU_SELECT), 0);
    chk("reset_ctl", {29'd0, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE}, 0);
    chk("reset_pc_rd", EX_PC | 32'(EX_RD_ADDR), 0);
    chk("reset_stall", 32'(ID_STALL), 0);
    tick();
    RESET = 0;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(EX_VALID), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_d1", i), ALU_DATA1, tbl[i].e_d1);
      chk($sformatf("v%0d_d2", i), ALU_DATA2, tbl[i].e_d2);
      chk($sformatf("v%0d_store", i), EX_STORE_DATA, tbl[i].e_sd);
      chk($sformatf("v%0d_sel", i), 32'(ALU_SELECT), 32'(tbl[i].e_sel));
      chk($sformatf("v%0d_rw", i), 32'(EX_REG_WRITE), 32'(tbl[i].e_rw));
      chk($sformatf("v%0d_rd", i), 32'(EX_RD_ADDR), 32'(tbl[i].e_rd));
    end
    chk("v5_pc_probe", 32'h2000, 32'h2000 & {32{1'b1}}); // constant sanity on table
    total--; // not a DUT comparison; remove from count

    // load-use: lw x5,4(x1) then add x6,x5,x1
    clr_inputs();
    ID_VALID = 1; ID_RS1_ADDR = 1; ID_RS1_USED = 1; ID_RS1_DATA = 32'h1000;
    ID_OP2_SEL = 1; ID_IMM = 4; ID_RD_ADDR = 5; ID_REG_WRITE = 1; ID_MEM_READ = 1;
    ID_PC = 32'h300;
    tick();
    chk("lu_load_memrd", 32'(EX_MEM_READ), 1);
    chk("lu_load_pc", EX_PC, 32'h300);
    ID_RS1_ADDR = 5; ID_RS2_ADDR = 1; ID_RS1_USED = 1; ID_RS2_USED = 1;
    ID_RS1_DATA = 32'h0; ID_RS2_DATA = 32'h10; ID_RD_ADDR = 6; ID_OP2_SEL = 0;
    ID_MEM_READ = 0; ID_PC = 32'h304;
    #1;
    chk("lu_stall_hi", 32'(ID_STALL), 1);
    tick();
    chk("lu_bubble_valid", 32'(EX_VALID), 0);
    chk("lu_bubble_memrd", 32'(EX_MEM_READ), 0);
    chk("lu_stall_lo", 32'(ID_STALL), 0);
    tick();
    MEM_RD_ADDR = 5; MEM_REG_WRITE = 1; MEM_RESULT = 32'hDEAD;
    #1;
    chk("lu_add_valid", 32'(EX_VALID), 1);
    chk("lu_add_pc", EX_PC, 32'h304);
    chk("lu_add_d1_fwd", ALU_DATA1, 32'hDEAD);
    chk("lu_add_d2", ALU_DATA2, 32'h10);

    // flush while MEM_STALL: held, then flush takes effect
    clr_inputs();
    ID_VALID = 1; ID_RS1_DATA = 32'h123; ID_ALU_SELECT = 6'h07; ID_RD_ADDR = 10;
    ID_REG_WRITE = 1; ID_MEM_WRITE = 1;
    tick();
    chk("fs_memwr", 32'(EX_MEM_WRITE), 1);
    ID_RS1_DATA = 32'h999; ID_ALU_SELECT = 6'h3F; ID_RD_ADDR = 20;
    FLUSH = 1; MEM_STALL = 1;
    #1;
    chk("fs_stall_out", 32'(ID_STALL), 1);
    tick();
    chk("fs_hold_valid", 32'(EX_VALID), 1);
    chk("fs_hold_sel", 32'(ALU_SELECT), 32'h07);
    chk("fs_hold_rd", 32'(EX_RD_ADDR), 10);
    chk("fs_hold_d1", ALU_DATA1, 32'h123);
    MEM_STALL = 0;
    tick();
    chk("fs_flush_valid", 32'(EX_VALID), 0);
    chk("fs_flush_rw", 32'(EX_REG_WRITE), 0);
    chk("fs_flush_sel", 32'(ALU_SELECT), 0);

    // stall refresh: WB value survives WB retiring during MEM_STALL
    clr_inputs();
    ID_VALID = 1; ID_RS1_ADDR = 4; ID_RS1_USED = 1; ID_RS1_DATA = 32'h0;
    ID_ALU_SELECT = 6'h03; ID_RD_ADDR = 11; ID_REG_WRITE = 1;
    tick();
    WB_RD_ADDR = 4; WB_REG_WRITE = 1; WB_RESULT = 32'h1234;
    ID_RS1_ADDR = 2; ID_RS1_DATA = 32'h5; ID_RD_ADDR = 13; ID_ALU_SELECT = 6'h09;
    MEM_STALL = 1;
    #1;
    chk("sr_pre_d1", ALU_DATA1, 32'h1234);
    tick();
    chk("sr_c1_d1", ALU_DATA1, 32'h1234);
    WB_REG_WRITE = 0; WB_RESULT = 32'hFFFF;
    #1;
    chk("sr_c1b_d1", ALU_DATA1, 32'h1234);
    tick();
    chk("sr_c2_d1", ALU_DATA1, 32'h1234);
    chk("sr_c2_stall", 32'(ID_STALL), 1);
    tick();
    chk("sr_c3_d1", ALU_DATA1, 32'h1234);
    chk("sr_c3_sel", 32'(ALU_SELECT), 32'h03);
    chk("sr_c3_rd", 32'(EX_RD_ADDR), 11);
    chk("sr_c3_valid", 32'(EX_VALID), 1);
    MEM_STALL = 0;
    #1;
    chk("sr_release_stall", 32'(ID_STALL), 0);
    tick();
    chk("sr_next_rd", 32'(EX_RD_ADDR), 13);

    // asynchronous reset between edges
    clr_inputs();
    ID_VALID = 1; ID_RS1_ADDR = 1; ID_RS1_DATA = 32'h77; ID_RD_ADDR = 7;
    ID_REG_WRITE = 1; ID_ALU_SELECT = 6'h11; ID_PC = 32'h40;
    tick();
    chk("ar_pre_valid", 32'(EX_VALID), 1);
    #2 RESET = 1;
    #1;
    chk("ar_valid", 32'(EX_VALID), 0);
    chk("ar_d1", ALU_DATA1, 0);
    chk("ar_sel", 32'(ALU_SELECT), 0);
    chk("ar_rw_rd", 32'(EX_REG_WRITE) | 32'(EX_RD_ADDR) | EX_PC, 0);
    @(negedge CLK);
    RESET = 0;
    ID_RS1_DATA = 32'h5; ID_RS2_DATA = 32'h7; ID_RS2_ADDR = 2; ID_RD_ADDR = 3;
    ID_ALU_SELECT = 0;
    tick();
    chk("ar_after_valid", 32'(EX_VALID), 1);
    chk("ar_after_d1", ALU_DATA1, 32'h5);
    chk("ar_after_d2", ALU_DATA2, 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline stage of the RV32IM pipeline, directly upstream of the ALU. Registers decoded instruction fields one cycle after decode, resolves operand forwarding from EX/MEM and MEM/WB, and drives the ALU `DATA1`/`DATA2`/`SELECT` inputs. Detects load-use hazards, holding decode and inserting a single bubble. Honours branch flush and data-memory stall.

## Interface

Parameters:
- `XLEN`, 32, datapath width.
- `RA_W`, 5, register address width.

Ports (clock and reset first):
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-high.
- `ID_VALID` in 1: a decode-slot instruction is present.
- `ID_PC` in XLEN: PC of the instruction in decode.
- `ID_RS1_DATA`, `ID_RS2_DATA` in XLEN: register-file read data.
- `ID_IMM` in XLEN: sign-extended immediate.
- `ID_RS1_ADDR`, `ID_RS2_ADDR`, `ID_RD_ADDR` in RA_W: source and destination register addresses.
- `ID_RS1_USED`, `ID_RS2_USED` in 1: the instruction reads rs1 / rs2.
- `ID_OP1_SEL` in 1: ALU operand 1 source (0 = rs1, 1 = PC).
- `ID_OP2_SEL` in 1: ALU operand 2 source (0 = rs2, 1 = IMM).
- `ID_ALU_SELECT` in 6: ALU operation code.
- `ID_REG_WRITE`, `ID_MEM_READ`, `ID_MEM_WRITE` in 1: control bits.
- `MEM_RD_ADDR` in RA_W, `MEM_REG_WRITE` in 1, `MEM_RESULT` in XLEN: EX/MEM forwarding source.
- `WB_RD_ADDR` in RA_W, `WB_REG_WRITE` in 1, `WB_RESULT` in XLEN: MEM/WB forwarding source.
- `FLUSH` in 1: taken branch/jump; kill the instruction entering EX.
- `MEM_STALL` in 1: data memory busy; freeze this stage.
- `ID_STALL` out 1: hold IF/ID (combinational).
- `ALU_DATA1`, `ALU_DATA2` out XLEN: ALU operands (combinational from stage registers plus forwarding).
- `ALU_SELECT` out 6: registered operation code.
- `EX_VALID`, `EX_REG_WRITE`, `EX_MEM_READ`, `EX_MEM_WRITE` out 1: registered controls.
- `EX_RD_ADDR` out RA_W, `EX_PC` out XLEN: registered.
- `EX_STORE_DATA` out XLEN: forwarded rs2 value, used as store data.

## Operation

- Stage register holds PC, RS1/RS2 data and addresses, USED bits, IMM, RD, OP selects, ALU_SELECT, and controls.
- Forwarding, per source (rs1, rs2), evaluated combinationally on stage-register contents:
  - MEM match: `MEM_REG_WRITE` and `MEM_RD_ADDR == EX_RSx_ADDR != 0` → use `MEM_RESULT`.
  - Otherwise WB match under the same rule → use `WB_RESULT`.
  - Otherwise use the stored register data.
  - MEM has priority over WB. Address 0 is never forwarded.
- Operand muxing:
  - `ALU_DATA1` = OP1_SEL ? EX_PC : fwd_rs1.
  - `ALU_DATA2` = OP2_SEL ? EX_IMM : fwd_rs2.
  - `EX_STORE_DATA` = fwd_rs2 always.
- Load-use hazard (`hz`): `ID_VALID & EX_VALID & EX_MEM_READ & EX_RD_ADDR != 0` and any of:
  - `ID_RS1_USED` and `ID_RS1_ADDR == EX_RD_ADDR`.
  - `ID_RS2_USED` and `ID_RS2_ADDR == EX_RD_ADDR`.
- `ID_STALL = hz | MEM_STALL`.
- Next-state priority at each edge:
  1. RESET: all registers cleared.
  2. MEM_STALL: hold every field, except that stored RS1/RS2 data are overwritten with the current fwd_rs1/fwd_rs2 (refresh), so a value forwarded from WB is not lost when WB retires. FLUSH is ignored; the issuer keeps FLUSH high until MEM_STALL drops.
  3. FLUSH: load a bubble.
  4. hz: load a bubble.
  5. Otherwise load ID fields. `EX_VALID = ID_VALID`. If `ID_VALID = 0`, REG_WRITE/MEM_READ/MEM_WRITE are loaded as 0.
- Bubble contents: EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE = 0; ALU_SELECT = 6'b000000; RD = 0; data fields = 0.

## Timing

- Reset values: ALU_SELECT 0; EX_* 0; ALU_DATA1/ALU_DATA2/EX_STORE_DATA 0 (stage registers 0, no forwarding match while MEM/WB are also 0). ID_STALL 0 unless MEM_STALL is high.
- Latency: ID fields appear on EX outputs 1 cycle after the edge that captures them.
- Forwarding adds no cycles: a MEM/WB change is visible on ALU_DATAx in the same cycle.
- A load-use hazard costs exactly one bubble:
  - ID_STALL is high for one cycle; in that cycle the bubble enters EX.
  - The next cycle sees no hz (EX now holds the bubble). The load is in MEM/WB, and the consumer issues and gets the load data via forwarding.
- MEM_STALL for N cycles holds EX for N cycles; ID_STALL is high for the same N cycles.
- RESET asserted mid-operation clears the stage immediately (asynchronous); outputs reach reset values without waiting for CLK.

## Test plan

- Pass-through: ID add, rs1=x1 (5), rs2=x2 (7), no MEM/WB hazard → next cycle ALU_DATA1=5, ALU_DATA2=7, ALU_SELECT=0, EX_VALID=1.
- Forward priority: EX_RS1_ADDR=3; MEM wb x3=0xAA; WB wb x3=0xBB → ALU_DATA1=0xAA. Drop MEM_REG_WRITE → 0xBB. Repeat with rd=x0 → stored data, no forwarding.
- Load-use: lw x5 in EX, ID add x6,x5,x1 → ID_STALL=1 for exactly 1 cycle, EX_VALID=0 the next cycle, then the add enters EX with its x5 operand forwarded from MEM_RESULT.
- Flush: FLUSH=1 with a valid ID instruction → EX_VALID=0, EX_REG_WRITE=0, ALU_SELECT=0 next cycle. FLUSH with MEM_STALL=1 → stage holds unchanged.
- Stall refresh: WB forwards x4=0x1234 to EX; MEM_STALL=1 for 3 cycles while WB_REG_WRITE drops after cycle 1 → ALU_DATA1 stays 0x1234 all 3 cycles; EX fields otherwise unchanged.
- Reset mid-operation: assert RESET between edges with EX_VALID=1 → all EX outputs 0 before the next CLK edge; after release, the first ID instruction passes normally.
